// File: rtl/loader_pkg.sv
// ============================================================================
// loader_pkg : shared state encoding, memory RW codes and default capacity
// Revision   : 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

   localparam int DEFAULT_MEM_WORDS = 64;

   // Instruction memory RW pin: high = CPU fetch, low = write from loader
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/loader_word_assembler.sv
// ============================================================================
// loader_word_assembler : packs little-endian program bytes into 32-bit words
// Revision              : 1.0
// ============================================================================
`default_nettype none

module loader_word_assembler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_data,
   output logic [1:0]  byte_idx,
   output logic [31:0] word_next
);

   // Only three earlier bytes need storing; the fourth arrives live on byte_data.
   logic [23:0] lane_q, lane_d;
   logic [1:0]  idx_q, idx_d;

   assign word_next = {byte_data, lane_q};
   assign byte_idx  = idx_q;

   always_comb begin
      lane_d = lane_q;
      idx_d  = idx_q;
      if (clear) begin
         lane_d = '0;
         idx_d  = '0;
      end else if (accept) begin
         lane_d = word_next[31:8];
         idx_d  = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q <= '0;
         idx_q  <= '0;
      end else begin
         lane_q <= lane_d;
         idx_q  <= idx_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/instruction_loader.sv
// ============================================================================
// instruction_loader : streams host bytes into instruction memory, holds CPU
// Revision           : 1.0
// ============================================================================
`default_nettype none

module instruction_loader
   import loader_pkg::*;
#(
   parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
   parameter int ADDR_W    = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic [31:0]       imem_data,
   output logic [ADDR_W-1:0] imem_address,
   output logic              imem_rw,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [15:0]       word_count
);

   localparam int IDX_W = $clog2(MEM_WORDS) + 1;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  word_idx_q, word_idx_d;
   logic [15:0]       word_count_q, word_count_d;
   logic              last_q, last_d;
   logic              byte_ready_q, byte_ready_d;
   logic [31:0]       imem_data_q, imem_data_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic              imem_rw_q, imem_rw_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic              asm_clear;
   logic              accept;
   logic [1:0]        byte_idx;
   logic [31:0]       word_next;
   logic [IDX_W-1:0]  idx_inc;

   assign accept  = byte_valid & byte_ready_q;
   assign idx_inc = word_idx_q + IDX_W'(1);

   loader_word_assembler u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (asm_clear),
      .accept    (accept),
      .byte_data (byte_data),
      .byte_idx  (byte_idx),
      .word_next (word_next)
   );

   always_comb begin
      state_d      = state_q;
      word_idx_d   = word_idx_q;
      word_count_d = word_count_q;
      last_d       = last_q;
      imem_rw_d    = RW_READ;
      imem_addr_d  = '0;
      imem_data_d  = '0;
      asm_clear    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_d      = ST_RECV;
               word_idx_d   = '0;
               word_count_d = '0;
               last_d       = 1'b0;
               asm_clear    = 1'b1;
            end
         end
         ST_RECV: begin
            if (accept) begin
               if (byte_idx == 2'd3) begin
                  // Strobe is registered so it lands exactly in the WRITE cycle.
                  state_d     = ST_WRITE;
                  last_d      = byte_last;
                  imem_rw_d   = RW_WRITE;
                  imem_addr_d = ADDR_W'({word_idx_q, 2'b00});
                  imem_data_d = word_next;
               end else if (byte_last) begin
                  state_d = ST_ERROR;
               end
            end
         end
         ST_WRITE: begin
            word_idx_d   = idx_inc;
            word_count_d = word_count_q + 16'd1;
            if (last_q)
               state_d = ST_DONE;
            else if (idx_inc == IDX_W'(MEM_WORDS))
               state_d = ST_ERROR;
            else
               state_d = ST_RECV;
         end
         default: state_d = ST_IDLE;
      endcase

      byte_ready_d = (state_d == ST_RECV);
      cpu_hold_d   = (state_d != ST_DONE);
      done_d       = (state_d == ST_DONE);
      error_d      = (state_d == ST_ERROR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         word_idx_q   <= '0;
         word_count_q <= '0;
         last_q       <= 1'b0;
         byte_ready_q <= 1'b0;
         imem_data_q  <= '0;
         imem_addr_q  <= '0;
         imem_rw_q    <= RW_READ;
         cpu_hold_q   <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_idx_q   <= word_idx_d;
         word_count_q <= word_count_d;
         last_q       <= last_d;
         byte_ready_q <= byte_ready_d;
         imem_data_q  <= imem_data_d;
         imem_addr_q  <= imem_addr_d;
         imem_rw_q    <= imem_rw_d;
         cpu_hold_q   <= cpu_hold_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign byte_ready   = byte_ready_q;
   assign imem_data    = imem_data_q;
   assign imem_address = imem_addr_q;
   assign imem_rw      = imem_rw_q;
   assign cpu_hold     = cpu_hold_q;
   assign done         = done_q;
   assign error        = error_q;
   assign word_count   = word_count_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_loader.sv
// ============================================================================
// tb_instruction_loader : vector table, corner sequences and random loads
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_loader;

   typedef logic [7:0] bq_t[$];
   typedef struct { logic [63:0] addr; logic [31:0] data; } wr_t;
   typedef struct {
      int          nbytes;
      logic [63:0] bytes;      // first program byte in bits 7:0
      bit          exp_done;
      bit          exp_err;
      int          exp_wc;
      logic [31:0] exp_w0;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic        byte_last = 1'b0;
   logic [7:0]  byte_data = 8'h00;

   logic        byte_ready, imem_rw, cpu_hold, done, error;
   logic [31:0] imem_data;
   logic [63:0] imem_address;
   logic [15:0] word_count;

   logic        byte_ready2, imem_rw2, cpu_hold2, done2, error2;
   logic [31:0] imem_data2;
   logic [63:0] imem_address2;
   logic [15:0] word_count2;

   int  checks = 0;
   int  failures = 0;
   wr_t wr_q[$];
   wr_t wr2_q[$];

   instruction_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
      .imem_data(imem_data), .imem_address(imem_address), .imem_rw(imem_rw),
      .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
   );

   instruction_loader #(.MEM_WORDS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready2),
      .imem_data(imem_data2), .imem_address(imem_address2), .imem_rw(imem_rw2),
      .cpu_hold(cpu_hold2), .done(done2), .error(error2), .word_count(word_count2)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Record every write cycle; also outside writes a held CPU must see address 0.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (imem_rw === 1'b0) wr_q.push_back('{imem_address, imem_data});
         if (imem_rw2 === 1'b0) wr2_q.push_back('{imem_address2, imem_data2});
         if (imem_rw === 1'b1 && cpu_hold === 1'b1) check("idle_addr_zero", imem_address, 64'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input bit last, input bit poke_start);
      int n;
      n = 0;
      byte_valid = 1'b1; byte_data = d; byte_last = last; start = poke_start;
      while (byte_ready !== 1'b1 && n < 20) begin step(); n++; end
      if (byte_ready === 1'b1) step();
      else check("handshake_timeout", 64'd0, 64'd1);
      byte_valid = 1'b0; byte_last = 1'b0; start = 1'b0; byte_data = 8'($urandom);
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (done !== 1'b1 && error !== 1'b1 && n < 10) begin step(); n++; end
      if (done !== 1'b1 && error !== 1'b1) check("end_timeout", 64'd0, 64'd1);
   endtask

   task automatic load(input bq_t prog, input int max_gap, input bit noisy);
      wr_q.delete();
      start = 1'b1; step(); start = 1'b0;
      foreach (prog[i]) begin
         repeat ($urandom_range(0, max_gap)) step();
         send_byte(prog[i], i == prog.size() - 1, noisy && ($urandom_range(0, 3) == 0));
      end
      wait_end();
   endtask

   // Expected results straight from the byte stream: complete words are
   // written to consecutive word addresses, a trailing partial word is an error.
   task automatic check_model(input bq_t prog, input string tag);
      int nw;
      bit ok_len;
      logic [31:0] w;
      nw = prog.size() / 4;
      ok_len = (prog.size() % 4 == 0);
      check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(nw));
      for (int k = 0; k < nw && k < wr_q.size(); k++) begin
         w = {prog[4*k+3], prog[4*k+2], prog[4*k+1], prog[4*k]};
         check({tag, "_addr"}, wr_q[k].addr, 64'(4 * k));
         check({tag, "_data"}, 64'(wr_q[k].data), 64'(w));
      end
      check({tag, "_done"}, 64'(done), 64'(ok_len));
      check({tag, "_error"}, 64'(error), 64'(!ok_len));
      check({tag, "_hold"}, 64'(cpu_hold), 64'(!ok_len));
      check({tag, "_wc"}, 64'(word_count), 64'(nw));
      check({tag, "_ready"}, 64'(byte_ready), 64'd0);
   endtask

   initial begin
      vec_t vecs[5];
      bq_t  prog;
      vecs[0] = '{4, 64'h0000_0000_00A0_0513, 1'b1, 1'b0, 1, 32'h00A0_0513};
      vecs[1] = '{2, 64'h0000_0000_0000_BEEF, 1'b0, 1'b1, 0, 32'h0};
      vecs[2] = '{8, 64'h0807_0605_0403_0201, 1'b1, 1'b0, 2, 32'h0403_0201};
      vecs[3] = '{5, 64'h0000_0055_DDCC_BBAA, 1'b0, 1'b1, 1, 32'hDDCC_BBAA};
      vecs[4] = '{1, 64'h0000_0000_0000_0077, 1'b0, 1'b1, 0, 32'h0};

      // Reset state
      repeat (3) step();
      check("rst_ready", 64'(byte_ready), 64'd0);
      check("rst_hold", 64'(cpu_hold), 64'd1);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_rw", 64'(imem_rw), 64'd1);
      check("rst_wc", 64'(word_count), 64'd0);
      check("rst_addr", imem_address, 64'd0);
      check("rst_data", 64'(imem_data), 64'd0);
      rst_n = 1'b1;
      step();
      check("idle_ready", 64'(byte_ready), 64'd0);

      // Single word: strobe exactly in the cycle after the 4th byte
      wr_q.delete();
      start = 1'b1; step(); start = 1'b0;
      check("recv_ready", 64'(byte_ready), 64'd1);
      send_byte(8'h13, 1'b0, 1'b0);
      send_byte(8'h05, 1'b0, 1'b0);
      send_byte(8'hA0, 1'b0, 1'b0);
      send_byte(8'h00, 1'b1, 1'b0);
      check("wr_cycle_rw", 64'(imem_rw), 64'd0);
      check("wr_cycle_addr", imem_address, 64'd0);
      check("wr_cycle_data", 64'(imem_data), 64'h00A0_0513);
      check("wr_cycle_ready", 64'(byte_ready), 64'd0);
      step();
      check("post_wr_rw", 64'(imem_rw), 64'd1);
      check("post_wr_done", 64'(done), 64'd1);
      check("post_wr_hold", 64'(cpu_hold), 64'd0);
      check("post_wr_wc", 64'(word_count), 64'd1);
      step();
      check("one_strobe", 64'(wr_q.size()), 64'd1);

      // Vector table
      foreach (vecs[v]) begin
         prog.delete();
         for (int i = 0; i < vecs[v].nbytes; i++) prog.push_back(vecs[v].bytes[8*i +: 8]);
         load(prog, 1, 1'b0);
         step();
         check("vec_done", 64'(done), 64'(vecs[v].exp_done));
         check("vec_error", 64'(error), 64'(vecs[v].exp_err));
         check("vec_hold", 64'(cpu_hold), 64'(!vecs[v].exp_done));
         check("vec_wc", 64'(word_count), 64'(vecs[v].exp_wc));
         check("vec_nwrites", 64'(wr_q.size()), 64'(vecs[v].exp_wc));
         if (wr_q.size() > 0 && vecs[v].exp_wc > 0)
            check("vec_w0", 64'(wr_q[0].data), 64'(vecs[v].exp_w0));
      end

      // Two words with idle gaps on byte_valid
      prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      load(prog, 4, 1'b0);
      check_model(prog, "gaps");

      // Capacity limit on the 2-word instance
      wr_q.delete(); wr2_q.delete();
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i), 1'b0, 1'b0);
      step();
      check("cap_error", 64'(error2), 64'd1);
      check("cap_ready", 64'(byte_ready2), 64'd0);
      check("cap_hold", 64'(cpu_hold2), 64'd1);
      check("cap_done", 64'(done2), 64'd0);
      byte_valid = 1'b1; byte_data = 8'hEE;
      repeat (4) step();
      byte_valid = 1'b0;
      step();
      check("cap_nwrites", 64'(wr2_q.size()), 64'd2);
      if (wr2_q.size() == 2) begin
         check("cap_addr0", wr2_q[0].addr, 64'd0);
         check("cap_addr1", wr2_q[1].addr, 64'd4);
         check("cap_data1", 64'(wr2_q[1].data), 64'hC7C6_C5C4);
      end
      check("cap_still_err", 64'(error2), 64'd1);

      // Reset mid-load discards the partial word
      start = 1'b1; step(); start = 1'b0;
      send_byte(8'hAA, 1'b0, 1'b0);
      send_byte(8'hBB, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("async_rst_ready", 64'(byte_ready), 64'd0);
      check("async_rst_hold", 64'(cpu_hold), 64'd1);
      check("async_rst_rw", 64'(imem_rw), 64'd1);
      step();
      rst_n = 1'b1;
      step();
      prog = '{8'h93, 8'h00, 8'h10, 8'h00};
      load(prog, 0, 1'b0);
      check_model(prog, "after_rst");

      // Random loads against the stream model, with ignored start pulses
      for (int t = 0; t < 20; t++) begin
         prog.delete();
         for (int i = 0; i < int'($urandom_range(1, 24)); i++) prog.push_back(8'($urandom));
         load(prog, 3, 1'b1);
         check_model(prog, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, meaning instruction memory capacity in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 64, meaning byte-address width driven to instruction memory (matches PC width).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin a new program load, sampled each cycle.
REQ-006 SHALL have port byte_valid  input  1  host presents a program byte.
REQ-007 SHALL have port byte_data  input  8  program byte.
REQ-008 SHALL have port byte_last  input  1  qualifies the final byte of the program.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port imem_data  output  32  word written to instruction memory (dataIn).
REQ-011 SHALL have port imem_address  output  ADDR_W  byte address to instruction memory.
REQ-012 SHALL have port imem_rw  output  1  instruction memory RW: 1 = read (CPU fetch), 0 = write.
REQ-013 SHALL have port cpu_hold  output  1  high holds PC/CPU stalled (drives PC enable low).
REQ-014 SHALL have ports done  output  1  program loaded; error  output  1  load aborted; word_count  output  16  words written.

Function
REQ-015 SHALL implement FSM states IDLE, RECV, WRITE, DONE, ERROR.
REQ-016 IDLE, DONE, ERROR: start=1 -> RECV, clearing byte index, word index, word_count, assembled word; byte_ready=0 in these states.
REQ-017 RECV: byte_ready=1; handshake byte_valid & byte_ready places byte_data into lane byte_idx (little-endian: first byte bits 7:0), byte_idx increments mod 4.
REQ-018 Acceptance of the 4th byte (byte_idx=3) at edge N SHALL enter WRITE; write strobe (imem_rw=0) active for exactly cycle N+1; byte_ready=0 in WRITE.
REQ-019 In WRITE, imem_address SHALL equal word index x 4 and imem_data the assembled word; at the end of WRITE word index and word_count increment by 1.
REQ-020 WRITE exit: -> DONE if byte_last accompanied the 4th byte; else -> ERROR if word index after increment equals MEM_WORDS; else -> RECV.
REQ-021 byte_last accepted with byte_idx != 3 SHALL go to ERROR with no memory write of the partial word.
REQ-022 Outside WRITE imem_rw SHALL be 1 and imem_address SHALL be 0 when cpu_hold=1.
REQ-023 cpu_hold SHALL be 0 only in DONE; done=1 only in DONE; error=1 only in ERROR.
REQ-024 start asserted in RECV or WRITE SHALL be ignored.
REQ-025 byte_valid low in RECV SHALL stall indefinitely with no state change; peak throughput one word per 5 cycles.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, byte_ready=0, imem_rw=1, imem_data=0, imem_address=0, cpu_hold=1, done=0, error=0, word_count=0.
REQ-027 Reset mid-load SHALL discard any partial word; the next load starts at address 0.

Structure
REQ-028 State encoding, RW read/write constants and default MEM_WORDS SHALL live in shared package loader_pkg.
REQ-029 Byte-to-word assembly SHALL be sub-module loader_word_assembler (lane shift register + byte index); FSM and address counter stay in instruction_loader.

Verification
REQ-030 Reset -> byte_ready=0, cpu_hold=1, done=0, error=0, imem_rw=1, word_count=0.
REQ-031 start; bytes 0x13,0x05,0xA0,0x00, last on 4th -> one cycle imem_rw=0, imem_data=0x00A00513, imem_address=0; then done=1, cpu_hold=0, word_count=1.
REQ-032 Two words with idle gaps on byte_valid -> writes at addresses 0 and 4, each one cycle, word_count=2.
REQ-033 last on 2nd byte -> error=1, cpu_hold=1, no imem_rw=0 cycle.
REQ-034 MEM_WORDS=2, three words without last -> writes at 0 and 4, then error=1, byte_ready=0.
REQ-035 rst_n low after 2 bytes, restart with 4 bytes+last -> single write at address 0, done=1.
